// File: rtl/reply_sender.sv
// Packet FIFO that presents only complete replies to the host, one byte per ack handshake (2 cycles per byte).
// Optional REPLY_CHECKSUM_EN appends an XOR byte to each reply; the write side drops replies that do not fit.
module reply_sender #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             wr_last,
  output logic             wr_full,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [CNT_W-1:0] pending,
  output logic             reply_rdy,
  output logic [7:0]       reply,
  input  logic             reply_ack,
  output logic             reply_end
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FETCH   = 2'd1;
  localparam logic [1:0] S_PRESENT = 2'd2;
`ifdef REPLY_CHECKSUM_EN
  localparam logic [1:0] S_CSUM    = 2'd3;
`endif

  logic [8:0]       r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      r_pkt_start;
  logic             r_discard;
  logic             r_overflow;
  logic [CNT_W-1:0] r_pending;
  logic [1:0]       r_state;
  logic             r_reply_rdy;
  logic [7:0]       r_reply;
  logic             r_reply_end;
  logic             r_last;
`ifdef REPLY_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic [AW:0] w_used;
  logic        w_full;
  logic        w_wr_ok;
  logic        w_drop;
  logic        w_commit;
  logic        w_ack;
  logic        w_fin;

  // w_used counts uncommitted bytes too, so a reply being built can fill the FIFO
  assign w_used   = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_used == FULL_CNT);
  assign w_wr_ok  = wr_en & ~w_full & ~r_discard;
  assign w_drop   = wr_en & w_full & ~r_discard;
  assign w_commit = w_wr_ok & wr_last;
  assign w_ack    = reply_ack & r_reply_rdy;
  assign w_fin    = w_ack & (r_state == S_PRESENT) & r_last;

  assign wr_full   = w_full;
  assign overflow  = r_overflow;
  assign pending   = r_pending;
  assign reply_rdy = r_reply_rdy;
  assign reply     = r_reply;
  assign reply_end = r_reply_end;

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[AW-1:0]] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_pkt_start <= '0;
      r_discard   <= 1'b0;
      r_overflow  <= 1'b0;
      r_pending   <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (wr_last) r_pkt_start <= r_wr_ptr + PTR_ONE;
      end else if (w_drop) begin
        // an overflowing final byte ends the reply, so nothing is left to discard
        r_wr_ptr  <= r_pkt_start;
        r_discard <= ~wr_last;
      end else if (wr_en && r_discard && wr_last) begin
        r_discard <= 1'b0;
      end

      if (w_drop)            r_overflow <= 1'b1;
      else if (overflow_clr) r_overflow <= 1'b0;

      case ({w_commit, w_fin})
        2'b10:   r_pending <= r_pending + CNT_ONE;
        2'b01:   r_pending <= r_pending - CNT_ONE;
        default: r_pending <= r_pending;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_reply_rdy <= 1'b0;
      r_reply     <= '0;
      r_reply_end <= 1'b0;
      r_last      <= 1'b0;
`ifdef REPLY_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
`ifdef REPLY_CHECKSUM_EN
          r_csum <= '0;
`endif
          if (r_pending != '0) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_reply     <= r_mem[r_rd_ptr[AW-1:0]][7:0];
          r_last      <= r_mem[r_rd_ptr[AW-1:0]][8];
`ifdef REPLY_CHECKSUM_EN
          r_reply_end <= 1'b0;
`else
          r_reply_end <= r_mem[r_rd_ptr[AW-1:0]][8];
`endif
          r_reply_rdy <= 1'b1;
          r_state     <= S_PRESENT;
        end
        S_PRESENT: begin
          if (w_ack) begin
            r_reply_rdy <= 1'b0;
            r_reply_end <= 1'b0;
            r_rd_ptr    <= r_rd_ptr + PTR_ONE;
`ifdef REPLY_CHECKSUM_EN
            r_csum      <= r_csum ^ r_reply;
            r_state     <= r_last ? S_CSUM : S_FETCH;
`else
            r_state     <= r_last ? S_IDLE : S_FETCH;
`endif
          end
        end
`ifdef REPLY_CHECKSUM_EN
        S_CSUM: begin
          if (!r_reply_rdy) begin
            r_reply     <= r_csum;
            r_reply_end <= 1'b1;
            r_reply_rdy <= 1'b1;
          end else if (w_ack) begin
            r_reply_rdy <= 1'b0;
            r_reply_end <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reply_sender.sv
// Directed bench for reply_sender (DEPTH=16); expectations follow REPLY_CHECKSUM_EN when defined.
module tb_reply_sender;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_last = 1'b0;
  logic       wr_full;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic [7:0] pending;
  logic       reply_rdy;
  logic [7:0] reply;
  logic       reply_ack = 1'b0;
  logic       reply_end;

  int n_chk = 0;
  int n_fail = 0;

`ifdef REPLY_CHECKSUM_EN
  localparam logic LAST_END = 1'b0;
`else
  localparam logic LAST_END = 1'b1;
`endif

  reply_sender #(.DEPTH(16), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_full(wr_full), .overflow(overflow), .overflow_clr(overflow_clr),
    .pending(pending),
    .reply_rdy(reply_rdy), .reply(reply), .reply_ack(reply_ack), .reply_end(reply_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [7:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    @(posedge clk); #1;
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic get_byte(input string tag, input logic [7:0] d, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    while (!reply_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rdy"}, reply_rdy, 1);
    chk({tag, "_dat"}, reply, d);
    chk({tag, "_end"}, reply_end, e);
    reply_ack = 1'b1;
    @(posedge clk); #1;
    reply_ack = 1'b0;
  endtask

  task automatic idle_for(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen = seen | reply_rdy;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", reply_rdy, 0);
    chk("rst_pend", pending, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_end", reply_end, 0);
    chk("rst_dat", reply, 0);

    // 1: basic three-byte reply
    wb(8'h11, 0); wb(8'h22, 0); wb(8'h33, 1);
    @(negedge clk);
    chk("t1_pend1", pending, 1);
    get_byte("t1_b0", 8'h11, 0);
    get_byte("t1_b1", 8'h22, 0);
    get_byte("t1_b2", 8'h33, LAST_END);
`ifdef REPLY_CHECKSUM_EN
    get_byte("t1_cs", 8'h00, 1);
`endif
    @(negedge clk);
    chk("t1_pend0", pending, 0);
    chk("t1_rdy0", reply_rdy, 0);
    chk("t1_end0", reply_end, 0);

    // 2: incomplete reply is held back, commit-to-ready latency
    wb(8'hAA, 0); wb(8'hBB, 0);
    idle_for("t2_hold", 20);
    #1 wb(8'hCC, 1);
    @(negedge clk);
    chk("t2_lat1", reply_rdy, 0);
    @(negedge clk);
    chk("t2_lat2", reply_rdy, 0);
    @(negedge clk);
    chk("t2_lat3", reply_rdy, 1);
    chk("t2_first", reply, 8'hAA);
    get_byte("t2_b0", 8'hAA, 0);
    get_byte("t2_b1", 8'hBB, 0);
    get_byte("t2_b2", 8'hCC, LAST_END);
`ifdef REPLY_CHECKSUM_EN
    get_byte("t2_cs", 8'hDD, 1);
`endif

    // 3: 17-byte reply overflows a 16-byte FIFO and is dropped
    for (int i = 0; i < 16; i++) wb(8'(i), 0);
    @(negedge clk);
    chk("t3_full", wr_full, 1);
    chk("t3_pend_fill", pending, 0);
    #1 wb(8'hF0, 1);
    @(negedge clk);
    chk("t3_ovf", overflow, 1);
    chk("t3_pend", pending, 0);
    chk("t3_unfull", wr_full, 0);
    idle_for("t3_quiet", 10);
    #1 wb(8'h5A, 0); wb(8'hA5, 1);
    get_byte("t3_b0", 8'h5A, 0);
    get_byte("t3_b1", 8'hA5, LAST_END);
`ifdef REPLY_CHECKSUM_EN
    get_byte("t3_cs", 8'hFF, 1);
`endif
    @(negedge clk);
    chk("t3_ovf_sticky", overflow, 1);
    #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    @(negedge clk);
    chk("t3_ovf_clr", overflow, 0);

    // 4: commit of reply 2 coincides with final ack of reply 1
    wb(8'h10, 1);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!reply_rdy && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("t4_r1_rdy", reply_rdy, 1);
      chk("t4_r1_dat", reply, 8'h10);
      chk("t4_r1_end", reply_end, LAST_END);
      reply_ack = 1'b1; wr_en = 1'b1; wr_data = 8'h20; wr_last = 1'b1;
      @(posedge clk); #1;
      reply_ack = 1'b0; wr_en = 1'b0; wr_last = 1'b0;
    end
    @(negedge clk);
    chk("t4_pend_same", pending, 1);
`ifdef REPLY_CHECKSUM_EN
    get_byte("t4_cs1", 8'h10, 1);
`endif
    get_byte("t4_r2", 8'h20, LAST_END);
`ifdef REPLY_CHECKSUM_EN
    get_byte("t4_cs2", 8'h20, 1);
`endif
    @(negedge clk);
    chk("t4_pend0", pending, 0);

    // 5: reset after the first ack aborts the reply
    wb(8'hA1, 0); wb(8'hB2, 0); wb(8'hC3, 1);
    get_byte("t5_b0", 8'hA1, 0);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t5_rdy", reply_rdy, 0);
    chk("t5_pend", pending, 0);
    chk("t5_full", wr_full, 0);
    idle_for("t5_quiet", 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
